// File: rtl/aximm_csr_seq_pkg.sv
// -----------------------------------------------------------------------------
// aximm_csr_seq_pkg
// Shared definitions for the AXI-MM test CSR sequencer:
//   - main and bus FSM state encodings
//   - CSR byte offsets, RW_CTRL / STATUS field positions, PASS_CODE
//   - err_code encodings and an RW_CTRL word builder
// Optional build macro: AXIMM_CSR_SEQ_ONLINE_CHK_EN adds S_POLL_ONLINE.
// -----------------------------------------------------------------------------
package aximm_csr_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef AXIMM_CSR_SEQ_ONLINE_CHK_EN
        S_POLL_ONLINE,
`endif
        S_W_DX,
        S_W_DY,
        S_W_DZ,
        S_W_ADDR,
        S_W_KICKWR,
        S_POLL_WR,
        S_W_KICKRD,
        S_POLL_RD,
        S_R_RES,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WR,
        B_RD,
        B_RDV
    } bus_state_t;

    // CSR byte offsets
    localparam logic [31:0] ADDR_DELAY_X = 32'h0000_0000;
    localparam logic [31:0] ADDR_DELAY_Y = 32'h0000_0004;
    localparam logic [31:0] ADDR_DELAY_Z = 32'h0000_0008;
    localparam logic [31:0] ADDR_RW_CTRL = 32'h0000_000C;
    localparam logic [31:0] ADDR_RW_ADDR = 32'h0000_0010;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_0014;

    // STATUS field positions
    localparam int ST_WR_CMPL    = 0;
    localparam int ST_RD_CMPL    = 1;
    localparam int ST_CHKR_LSB   = 2;
    localparam int ST_ONLINE_LSB = 4;

    localparam logic [1:0] PASS_CODE = 2'b01;

    // err_code encodings
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_WR_POLL = 2'd1;
    localparam logic [1:0] ERR_RD_POLL = 2'd2;
    localparam logic [1:0] ERR_RDV     = 2'd3;

    // RW_CTRL: wr[0], rd[1], length[15:8], burst[17:16], size[20:18]
    function automatic logic [31:0] rw_ctrl_word(input logic       wr,
                                                 input logic       rd,
                                                 input logic [7:0] len,
                                                 input logic [1:0] burst,
                                                 input logic [2:0] size);
        return {11'd0, size, burst, len, 6'd0, rd, wr};
    endfunction

endpackage

// File: rtl/aximm_csr_seq_bus.sv
// -----------------------------------------------------------------------------
// aximm_csr_seq_bus
// Single-transaction Avalon-MM initiator with a built-in readdatavalid timeout.
//
// Handshake: the caller pulses i_req for one cycle, only while no transaction
// is outstanding (o_idle=1), with i_we/i_addr/i_wdata valid in that cycle.
// o_ack pulses for exactly one cycle when the transaction ends: for a write on
// the waitrequest=0 accept cycle, for a read on the readdatavalid cycle (which
// may be the accept cycle itself) or when the RDV timeout expires, in which
// case o_rdv_tmo is also high. o_rdata is valid only while o_ack=1.
// On the bus side address/data/strobe are registered and held unchanged while
// i_master_waitrequest=1; the strobe drops the cycle after accept.
//
// Ports: i_clk, i_rst (sync, active high); i_req/i_we/i_addr/i_wdata request;
//   o_idle, o_ack, o_rdv_tmo, o_rdata response; o_master_* / i_master_* bus.
// -----------------------------------------------------------------------------
module aximm_csr_seq_bus
    import aximm_csr_seq_pkg::*;
#(
    parameter int RDV_TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_idle,
    output logic        o_ack,
    output logic        o_rdv_tmo,
    output logic [31:0] o_rdata,
    output logic [31:0] o_master_address,
    output logic [31:0] o_master_writedata,
    output logic        o_master_write,
    output logic        o_master_read,
    input  logic        i_master_waitrequest,
    input  logic        i_master_readdatavalid,
    input  logic [31:0] i_master_readdata
);

    localparam int CW = $clog2(RDV_TIMEOUT + 1);

    bus_state_t    r_state, w_state_nxt;
    logic [31:0]   r_addr, w_addr_nxt;
    logic [31:0]   r_wdata, w_wdata_nxt;
    logic          r_write, w_write_nxt;
    logic          r_read, w_read_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= B_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_read  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_write <= w_write_nxt;
            r_read  <= w_read_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_write_nxt = r_write;
        w_read_nxt  = r_read;
        w_cnt_nxt   = r_cnt;
        o_ack       = 1'b0;
        o_rdv_tmo   = 1'b0;
        case (r_state)
            B_IDLE: begin
                if (i_req) begin
                    w_addr_nxt  = i_addr;
                    w_wdata_nxt = i_wdata;
                    w_write_nxt = i_we;
                    w_read_nxt  = !i_we;
                    w_state_nxt = i_we ? B_WR : B_RD;
                end
            end
            B_WR: begin
                if (!i_master_waitrequest) begin
                    w_write_nxt = 1'b0;
                    o_ack       = 1'b1;
                    w_state_nxt = B_IDLE;
                end
            end
            B_RD: begin
                if (!i_master_waitrequest) begin
                    w_read_nxt = 1'b0;
                    if (i_master_readdatavalid) begin
                        o_ack       = 1'b1;
                        w_state_nxt = B_IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = B_RDV;
                    end
                end
            end
            B_RDV: begin
                // r_cnt counts cycles already waited after accept, so the
                // timeout lands exactly RDV_TIMEOUT cycles after accept.
                if (i_master_readdatavalid) begin
                    o_ack       = 1'b1;
                    w_state_nxt = B_IDLE;
                end else if (r_cnt == CW'(RDV_TIMEOUT - 1)) begin
                    o_ack       = 1'b1;
                    o_rdv_tmo   = 1'b1;
                    w_state_nxt = B_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = B_IDLE;
        endcase
    end

    assign o_idle             = (r_state == B_IDLE);
    assign o_rdata            = i_master_readdata;
    assign o_master_address   = r_addr;
    assign o_master_writedata = r_wdata;
    assign o_master_write     = r_write;
    assign o_master_read      = r_read;

endmodule

// File: rtl/aximm_csr_seq.sv
// -----------------------------------------------------------------------------
// aximm_csr_seq
// Autonomous Avalon-MM CSR initiator running one AXI-MM loopback test:
// program DELAY_X/Y/Z and RW_ADDR, kick an AXI write and poll WR_CMPL, kick an
// AXI read and poll RD_CMPL, then read the checker result from STATUS.
//
// Build macro: AXIMM_CSR_SEQ_ONLINE_CHK_EN inserts S_POLL_ONLINE after IDLE,
// polling STATUS until ONLINE[7:4] are all ones.
//
// Ports:
//   i_clk, i_rst (sync, active high), i_start (one-cycle, accepted in IDLE)
//   i_cfg_*            test configuration, captured on start acceptance
//   o_master_* / i_master_*  Avalon-MM initiator interface
//   o_busy, o_done, o_pass, o_err_code, o_test_done  registered status
//   o_dbg_state        current main FSM state
// -----------------------------------------------------------------------------
module aximm_csr_seq
    import aximm_csr_seq_pkg::*;
#(
    parameter int POLL_GAP     = 16,
    parameter int POLL_TIMEOUT = 4096,
    parameter int RDV_TIMEOUT  = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_cfg_delay_x,
    input  logic [31:0] i_cfg_delay_y,
    input  logic [31:0] i_cfg_delay_z,
    input  logic [31:0] i_cfg_rw_addr,
    input  logic [7:0]  i_cfg_rw_length,
    input  logic [1:0]  i_cfg_rw_burst,
    input  logic [2:0]  i_cfg_rw_size,
    output logic [31:0] o_master_address,
    output logic [31:0] o_master_writedata,
    output logic        o_master_write,
    output logic        o_master_read,
    input  logic        i_master_waitrequest,
    input  logic        i_master_readdatavalid,
    input  logic [31:0] i_master_readdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [1:0]  o_err_code,
    output logic [1:0]  o_test_done,
    output logic [3:0]  o_dbg_state
);

    localparam int PCW = $clog2(POLL_TIMEOUT + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

`ifdef AXIMM_CSR_SEQ_ONLINE_CHK_EN
    localparam state_t FIRST_STATE = S_POLL_ONLINE;
`else
    localparam state_t FIRST_STATE = S_W_DX;
`endif

    state_t         r_state, w_state_nxt, w_adv_state;
    logic           r_pending, w_pending_nxt;
    logic [GCW-1:0] r_gap, w_gap_nxt;
    logic [PCW-1:0] r_poll_cnt, w_poll_cnt_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;
    logic           r_pass, w_pass_nxt;
    logic [1:0]     r_err, w_err_nxt;
    logic [1:0]     r_td, w_td_nxt;

    logic [31:0] r_cfg_dx, r_cfg_dy, r_cfg_dz, r_cfg_addr;
    logic [7:0]  r_cfg_len;
    logic [1:0]  r_cfg_burst;
    logic [2:0]  r_cfg_size;

    logic        w_req, w_we, w_ack, w_rdv_tmo, w_bus_idle;
    logic [31:0] w_addr, w_wdata, w_rdata;
    logic        w_accept, w_is_poll, w_poll_to, w_poll_hit;
    logic [1:0]  w_poll_err, w_chkr;
    logic        w_unused;

    assign w_accept  = (r_state == S_IDLE) && i_start;
    assign w_poll_to = (r_poll_cnt == PCW'(POLL_TIMEOUT));
    assign w_chkr    = w_rdata[ST_CHKR_LSB +: 2];
    assign w_unused  = ^{w_rdata[31:4], w_bus_idle};

    always_comb begin
        w_is_poll  = 1'b0;
        w_poll_hit = 1'b0;
        w_poll_err = ERR_WR_POLL;
        case (r_state)
`ifdef AXIMM_CSR_SEQ_ONLINE_CHK_EN
            S_POLL_ONLINE: begin
                w_is_poll  = 1'b1;
                w_poll_hit = &w_rdata[ST_ONLINE_LSB +: 4];
            end
`endif
            S_POLL_WR: begin
                w_is_poll  = 1'b1;
                w_poll_hit = w_rdata[ST_WR_CMPL];
            end
            S_POLL_RD: begin
                w_is_poll  = 1'b1;
                w_poll_hit = w_rdata[ST_RD_CMPL];
                w_poll_err = ERR_RD_POLL;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_adv_state = S_IDLE;
        case (r_state)
            S_IDLE:        w_adv_state = FIRST_STATE;
`ifdef AXIMM_CSR_SEQ_ONLINE_CHK_EN
            S_POLL_ONLINE: w_adv_state = S_W_DX;
`endif
            S_W_DX:        w_adv_state = S_W_DY;
            S_W_DY:        w_adv_state = S_W_DZ;
            S_W_DZ:        w_adv_state = S_W_ADDR;
            S_W_ADDR:      w_adv_state = S_W_KICKWR;
            S_W_KICKWR:    w_adv_state = S_POLL_WR;
            S_POLL_WR:     w_adv_state = S_W_KICKRD;
            S_W_KICKRD:    w_adv_state = S_POLL_RD;
            S_POLL_RD:     w_adv_state = S_R_RES;
            S_R_RES:       w_adv_state = S_DONE;
            default:       w_adv_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_gap_nxt      = r_gap;
        w_poll_cnt_nxt = r_poll_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_err_nxt      = r_err;
        w_td_nxt       = r_td;
        w_we           = 1'b0;
        w_addr         = ADDR_STATUS;
        w_wdata        = '0;

        case (r_state)
            S_W_DX:     begin w_we = 1'b1; w_addr = ADDR_DELAY_X; w_wdata = r_cfg_dx;   end
            S_W_DY:     begin w_we = 1'b1; w_addr = ADDR_DELAY_Y; w_wdata = r_cfg_dy;   end
            S_W_DZ:     begin w_we = 1'b1; w_addr = ADDR_DELAY_Z; w_wdata = r_cfg_dz;   end
            S_W_ADDR:   begin w_we = 1'b1; w_addr = ADDR_RW_ADDR; w_wdata = r_cfg_addr; end
            S_W_KICKWR: begin
                w_we    = 1'b1;
                w_addr  = ADDR_RW_CTRL;
                w_wdata = rw_ctrl_word(1'b1, 1'b0, r_cfg_len, r_cfg_burst, r_cfg_size);
            end
            S_W_KICKRD: begin
                w_we    = 1'b1;
                w_addr  = ADDR_RW_CTRL;
                w_wdata = rw_ctrl_word(1'b0, 1'b1, r_cfg_len, r_cfg_burst, r_cfg_size);
            end
            default: ;
        endcase

        // One bus transaction at a time; poll phases also honour the gap and
        // stop issuing once the phase budget is used up.
        w_req = (r_state != S_IDLE) && (r_state != S_DONE) && !r_pending &&
                (r_gap == '0) && !(w_is_poll && w_poll_to);
        if (w_req) w_pending_nxt = 1'b1;

        if (w_is_poll) begin
            w_poll_cnt_nxt = w_poll_to ? r_poll_cnt : r_poll_cnt + 1'b1;
            if (!r_pending && (r_gap != '0)) w_gap_nxt = r_gap - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_err_nxt      = ERR_NONE;
                    w_td_nxt       = 2'd0;
                    w_poll_cnt_nxt = '0;
                    w_gap_nxt      = '0;
                    w_state_nxt    = w_adv_state;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                if (w_ack) begin
                    w_pending_nxt = 1'b0;
                    if (w_rdv_tmo) begin
                        w_err_nxt   = ERR_RDV;
                        w_state_nxt = S_DONE;
                    end else if (w_is_poll && !w_poll_hit) begin
                        if (w_poll_to) begin
                            w_err_nxt   = w_poll_err;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_gap_nxt = GCW'(POLL_GAP);
                        end
                    end else begin
                        if (r_state == S_R_RES) begin
                            w_td_nxt   = w_chkr;
                            w_pass_nxt = (w_chkr == PASS_CODE);
                        end
                        // Every state change restarts the phase counters.
                        w_state_nxt    = w_adv_state;
                        w_poll_cnt_nxt = '0;
                        w_gap_nxt      = '0;
                    end
                end else if (w_is_poll && !r_pending && w_poll_to) begin
                    w_err_nxt   = w_poll_err;
                    w_state_nxt = S_DONE;
                end
                if (w_state_nxt == S_DONE) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b0;
            r_gap      <= '0;
            r_poll_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= ERR_NONE;
            r_td       <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_gap      <= w_gap_nxt;
            r_poll_cnt <= w_poll_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err      <= w_err_nxt;
            r_td       <= w_td_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg_dx    <= '0;
            r_cfg_dy    <= '0;
            r_cfg_dz    <= '0;
            r_cfg_addr  <= '0;
            r_cfg_len   <= '0;
            r_cfg_burst <= '0;
            r_cfg_size  <= '0;
        end else if (w_accept) begin
            r_cfg_dx    <= i_cfg_delay_x;
            r_cfg_dy    <= i_cfg_delay_y;
            r_cfg_dz    <= i_cfg_delay_z;
            r_cfg_addr  <= i_cfg_rw_addr;
            r_cfg_len   <= i_cfg_rw_length;
            r_cfg_burst <= i_cfg_rw_burst;
            r_cfg_size  <= i_cfg_rw_size;
        end
    end

    aximm_csr_seq_bus #(
        .RDV_TIMEOUT (RDV_TIMEOUT)
    ) u_bus (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_req                  (w_req),
        .i_we                   (w_we),
        .i_addr                 (w_addr),
        .i_wdata                (w_wdata),
        .o_idle                 (w_bus_idle),
        .o_ack                  (w_ack),
        .o_rdv_tmo              (w_rdv_tmo),
        .o_rdata                (w_rdata),
        .o_master_address       (o_master_address),
        .o_master_writedata     (o_master_writedata),
        .o_master_write         (o_master_write),
        .o_master_read          (o_master_read),
        .i_master_waitrequest   (i_master_waitrequest),
        .i_master_readdatavalid (i_master_readdatavalid),
        .i_master_readdata      (i_master_readdata)
    );

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_code  = r_err;
    assign o_test_done = r_td;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aximm_csr_seq.sv
`timescale 1ns/1ps
module tb_aximm_csr_seq;

    localparam int POLL_GAP     = 3;
    localparam int POLL_TIMEOUT = 64;
    localparam int RDV_TIMEOUT  = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_dx = '0, cfg_dy = '0, cfg_dz = '0, cfg_addr = '0;
    logic [7:0]  cfg_len = '0;
    logic [1:0]  cfg_burst = '0;
    logic [2:0]  cfg_size = '0;
    logic [31:0] m_addr, m_wdata;
    logic        m_write, m_read;
    logic        m_wait = 1'b0, m_rdv = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy, done, pass;
    logic [1:0]  err_code, test_done;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    aximm_csr_seq #(
        .POLL_GAP     (POLL_GAP),
        .POLL_TIMEOUT (POLL_TIMEOUT),
        .RDV_TIMEOUT  (RDV_TIMEOUT)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_start                (start),
        .i_cfg_delay_x          (cfg_dx),
        .i_cfg_delay_y          (cfg_dy),
        .i_cfg_delay_z          (cfg_dz),
        .i_cfg_rw_addr          (cfg_addr),
        .i_cfg_rw_length        (cfg_len),
        .i_cfg_rw_burst         (cfg_burst),
        .i_cfg_rw_size          (cfg_size),
        .o_master_address       (m_addr),
        .o_master_writedata     (m_wdata),
        .o_master_write         (m_write),
        .o_master_read          (m_read),
        .i_master_waitrequest   (m_wait),
        .i_master_readdatavalid (m_rdv),
        .i_master_readdata      (m_rdata),
        .o_busy                 (busy),
        .o_done                 (done),
        .o_pass                 (pass),
        .o_err_code             (err_code),
        .o_test_done            (test_done),
        .o_dbg_state            (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];     // expected writes {addr, data}
    logic [4:0]  res_q[$];     // expected {err_code, test_done, pass}
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_accepts = 0, rd_accepts = 0, done_rises = 0;
    int rd_accept_edge = 0;
    int done_cyc = 0;

    // responder configuration
    int          wr_wait = 0, rd_wait = 0, rdv_lat = 0;
    bit          rdv_en = 1'b1;
    logic [31:0] status_val = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- CSR slave responder ----------------
    initial begin
        int          stall;
        int          rdv_cd;
        logic [31:0] hold_a, hold_d;
        stall  = 0;
        rdv_cd = -1;
        hold_a = '0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            m_rdv = 1'b0;
            if (rst) begin
                stall  = 0;
                rdv_cd = -1;
                m_wait = 1'b0;
                continue;
            end
            if (rdv_cd == 0) begin
                m_rdv   = 1'b1;
                m_rdata = status_val;
            end
            if (rdv_cd >= 0) rdv_cd--;
            if (m_write || m_read) begin
                check("wr_rd_excl", m_write & m_read, 0);
                if (stall == 0) begin
                    hold_a = m_addr;
                    hold_d = m_wdata;
                end else begin
                    check("hold_addr", m_addr, hold_a);
                    check("hold_data", m_wdata, hold_d);
                end
                if (stall < (m_write ? wr_wait : rd_wait)) begin
                    m_wait = 1'b1;
                    stall++;
                end else begin
                    m_wait = 1'b0;
                    stall  = 0;
                    if (m_write) begin
                        wr_accepts++;
                        check("wr_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) check("wr_txn", {m_addr, m_wdata}, exp_q.pop_front());
                    end else begin
                        rd_accepts++;
                        rd_accept_edge = cyc + 1;
                        check("rd_addr", m_addr, 32'h14);
                        if (rdv_en) begin
                            if (rdv_lat == 0) begin
                                m_rdv   = 1'b1;
                                m_rdata = status_val;
                            end else begin
                                rdv_cd = rdv_lat - 1;
                            end
                        end
                    end
                end
            end else begin
                m_wait = 1'b0;
                stall  = 0;
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) done_rises++;
            prev = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [31:0] dx, dy, dz, addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        cfg_dx = dx; cfg_dy = dy; cfg_dz = dz; cfg_addr = addr;
        cfg_len = len; cfg_burst = burst; cfg_size = size;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected write sequence derived from the current cfg inputs.
    task automatic push_writes(input int n);
        logic [63:0] t[6];
        logic [31:0] ctrl;
        ctrl = ({29'd0, cfg_size} << 18) | ({30'd0, cfg_burst} << 16) | ({24'd0, cfg_len} << 8);
        t[0] = {32'h00, cfg_dx};
        t[1] = {32'h04, cfg_dy};
        t[2] = {32'h08, cfg_dz};
        t[3] = {32'h10, cfg_addr};
        t[4] = {32'h0C, ctrl | 32'h1};
        t[5] = {32'h0C, ctrl | 32'h2};
        for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", ok, 1);
    endtask

    task automatic run_seq(input string tag, input int n_wr, input logic [1:0] e_err,
                           input logic [1:0] e_td, input logic e_pass, input bit scramble);
        bit          ok;
        int          wr0;
        logic [4:0]  r;
        push_writes(n_wr);
        res_q.push_back({e_err, e_td, e_pass});
        wr0 = wr_accepts;
        pulse_start();
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        // cfg inputs must have been captured at acceptance
        if (scramble) set_cfg($urandom, $urandom, $urandom, $urandom, 8'($urandom), 2'($urandom), 3'($urandom));
        wait_done(4000, ok);
        if (ok) begin
            r = res_q.pop_front();
            check({tag, "_result"}, {err_code, test_done, pass}, r);
            check({tag, "_busy_at_done"}, busy, 0);
        end else begin
            res_q.delete();
        end
        check({tag, "_wr_left"}, exp_q.size(), 0);
        check({tag, "_wr_count"}, wr_accepts - wr0, n_wr);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int r0, d0, w0;

        repeat (3) @(negedge clk);
        check("rst_outputs", {m_addr, m_wdata, m_write, m_read, busy, done, pass, err_code, test_done}, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // No stall, CHKR=3 -> fail result
        set_cfg(32'h5, 32'h6, 32'h7, 32'h100, 8'd8, 2'd1, 3'd3);
        status_val = 32'h0F;
        run_seq("nostall_chkr3", 6, 2'd0, 2'd3, 1'b0, 1'b0);

        // CHKR=PASS_CODE, delayed readdatavalid, random cfg
        set_cfg($urandom, $urandom, $urandom, $urandom, 8'($urandom_range(0, 255)),
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        status_val = 32'h07;
        rdv_lat    = 2;
        run_seq("pass_rdvlat", 6, 2'd0, 2'd1, 1'b1, 1'b1);

        // waitrequest held 5 cycles on each write
        rdv_lat = 0;
        wr_wait = 5;
        set_cfg($urandom, $urandom, $urandom, $urandom, 8'd15, 2'd2, 3'd2);
        run_seq("stall5", 6, 2'd0, 2'd1, 1'b1, 1'b0);
        wr_wait = 0;

        // WR_CMPL never set -> write-poll timeout, no read kick
        status_val = 32'h00;
        r0 = rd_accepts;
        run_seq("wr_poll_to", 5, 2'd1, 2'd0, 1'b0, 1'b0);
        check("wr_poll_to_polled", rd_accepts - r0 > 1, 1);

        // readdatavalid never returned -> err 3, RDV_TIMEOUT after accept
        status_val = 32'h07;
        rdv_en     = 1'b0;
        r0 = rd_accepts;
        run_seq("rdv_to", 5, 2'd3, 2'd0, 1'b0, 1'b0);
        check("rdv_to_latency", done_cyc - rd_accept_edge, RDV_TIMEOUT);
        check("rdv_to_reads", rd_accepts - r0, 1);
        rdv_en = 1'b1;

        // Reset during a stalled W_DZ write
        wr_wait = 100;
        set_cfg(32'hA1, 32'hA2, 32'hA3, 32'h200, 8'd4, 2'd1, 3'd2);
        push_writes(2);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_write && m_addr == 32'h08) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_mid_reach_dz", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_write", m_write, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_wr_left", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b0;
        wr_wait = 0;
        @(negedge clk);
        run_seq("after_rst", 6, 2'd0, 2'd1, 1'b1, 1'b0);

        // start while busy and in the DONE cycle is ignored
        set_cfg(32'h11, 32'h22, 32'h33, 32'h400, 8'd2, 2'd0, 3'd1);
        push_writes(6);
        res_q.push_back({2'd0, 2'd1, 1'b1});
        d0 = done_rises;
        w0 = wr_accepts;
        pulse_start();
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4000, ok);
        if (ok) begin
            start = 1'b1;     // lands in the single DONE cycle
            check("ign_result", {err_code, test_done, pass}, res_q.pop_front());
            @(negedge clk);
            start = 1'b0;
        end
        repeat (60) @(negedge clk);
        check("ign_busy", busy, 0);
        check("ign_done_held", done, 1);
        check("ign_one_seq", done_rises - d0, 1);
        check("ign_wr_count", wr_accepts - w0, 6);
        check("ign_wr_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/aximm_csr_seq.md
Name: aximm_csr_seq

Overview:
- Avalon-MM style CSR initiator (master) for the AXI-MM test CSR block.
- Drives address, write data and write/read strobes, and honours waitrequest and readdatavalid.
- Autonomously runs one loopback test:
  - programs the delay and transfer registers;
  - kicks an AXI write and polls for completion;
  - kicks an AXI read and polls for completion;
  - reads back the checker result.
- Replaces TB/JTAG-driven CSR traffic on bring-up builds.

Parameters:
- POLL_GAP, 16: idle cycles between successive status polls (min 1).
- POLL_TIMEOUT, 4096: max cycles spent in a poll phase before error.
- RDV_TIMEOUT, 256: max cycles from read accept to readdatavalid.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; ignored while busy.
- cfg_delay_x  in  32  value for DELAY_X register.
- cfg_delay_y  in  32  value for DELAY_Y register.
- cfg_delay_z  in  32  value for DELAY_Z register.
- cfg_rw_addr  in  32  AXI transfer address.
- cfg_rw_length  in  8  AXI burst length.
- cfg_rw_burst  in  2  AXI burst type.
- cfg_rw_size  in  3  AXI beat size.
- master_address  out  32  CSR byte address.
- master_writedata  out  32  CSR write data.
- master_write  out  1  write request.
- master_read  out  1  read request.
- master_waitrequest  in  1  slave stall.
- master_readdatavalid  in  1  read data strobe.
- master_readdata  in  32  read data.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; held until next accepted start.
- pass  out  1  checker reported PASS_CODE.
- err_code  out  2  error type: 0 none, 1 write-poll timeout, 2 read-poll timeout, 3 readdatavalid timeout.
- test_done  out  2  checker field captured from STATUS.

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0. Reset mid-sequence drops master_write/master_read at the same edge; no bus cycle is completed.
- All outputs are registered.
- Start acceptance: start is accepted only in IDLE. All cfg_* inputs are captured at acceptance. Acceptance clears done, pass, err_code and test_done, and sets busy.
- Write cycle: address and data are driven with master_write=1 and held stable until the cycle where master_waitrequest=0 (accept). The strobe drops the next cycle and the FSM advances.
- Read cycle:
  - Driven the same way with master_read=1; the strobe drops after accept.
  - The FSM then waits for master_readdatavalid. readdatavalid in the accept cycle itself is legal and is taken.
  - Exceeding RDV_TIMEOUT sets err_code=3 and goes to DONE.
- FSM sequence: IDLE -> W_DX -> W_DY -> W_DZ -> W_ADDR -> W_KICKWR -> POLL_WR -> W_KICKRD -> POLL_RD -> R_RES -> DONE -> IDLE.
- Kick register writes:
  - W_KICKWR writes RW_CTRL with wr=1, rd=0 and the length/burst/size fields.
  - W_KICKRD writes RW_CTRL with wr=0, rd=1.
- Poll phases:
  - Read STATUS, then wait POLL_GAP cycles, then repeat.
  - POLL_WR exits on STATUS.WR_CMPL; POLL_RD exits on STATUS.RD_CMPL.
  - The cycle counter starts at phase entry and saturates.
  - Reaching POLL_TIMEOUT with no completion: the outstanding read is finished first, then err_code is set to 1 (POLL_WR) or 2 (POLL_RD) and the FSM goes to DONE.
- R_RES: reads STATUS, sets test_done to the CHKR field, and sets pass = (CHKR == PASS_CODE).
- DONE: lasts one cycle; sets done=1 and busy=0, then returns to IDLE.
- start arriving in the DONE cycle is ignored.
- master_write and master_read are never asserted together.

Optional Feature:
- Macro: AXIMM_CSR_SEQ_ONLINE_CHK_EN.
- Defined: a POLL_ONLINE state is inserted between IDLE and W_DX. It polls STATUS until all ONLINE bits [7:4] are 1, with the same POLL_GAP/POLL_TIMEOUT rules. Timeout sets err_code=1.
- Undefined: W_DX follows IDLE directly, and no POLL_ONLINE logic exists.

Decomposition:
- Package aximm_csr_seq_pkg holds:
  - state enum;
  - CSR byte offsets: DELAY_X=0x00, DELAY_Y=0x04, DELAY_Z=0x08, RW_CTRL=0x0C, RW_ADDR=0x10, STATUS=0x14;
  - RW_CTRL fields: wr[0], rd[1], length[15:8], burst[17:16], size[20:18];
  - STATUS fields: WR_CMPL[0], RD_CMPL[1], CHKR[3:2], ONLINE[7:4];
  - PASS_CODE=2'b01;
  - err_code encodings.
- One sub-module, aximm_csr_seq_bus: single-transaction Avalon initiator that takes a req/we/addr/wdata handshake and returns ack plus rdata, with the RDV timeout built in. The main FSM issues requests only through it.

Test Plan:
- No stall, waitrequest=0: start with delay_x=0x5, addr=0x100, length=8, burst=1, size=3 -> six writes in order. The RW_CTRL kick writes 0x00_0D_08_01 (=0x000D0801). STATUS=0x0F -> pass=1, test_done=2'b11? No: CHKR=2'b11 gives pass=0, test_done=3. Repeat with STATUS=0x07 -> pass=1, test_done=1.
- waitrequest held high 5 cycles on each write -> address and data stay stable for all 5 cycles. Exactly one accept per register, total of six writes.
- WR_CMPL never set, POLL_TIMEOUT=64 -> err_code=1, done=1, pass=0. No RW_CTRL read kick is issued.
- readdatavalid never returned, RDV_TIMEOUT=16 -> err_code=3 exactly 16 cycles after read accept.
- rst asserted during W_DZ with waitrequest=1 -> next cycle master_write=0 and busy=0. A fresh start then restarts from W_DX.
- start pulsed while busy and in the DONE cycle -> ignored; exactly one sequence completes.
